// File: rtl/team_09_fpga_io.sv
// rtl/team_09_fpga_io.sv - pushbutton sync/debounce/edge and seven-segment display register
// Optional feature macro: TEAM_09_PB_TOGGLE_EN (pb_level carries per-button toggle state)
module team_09_fpga_io #(
    parameter int          NUM_PB          = 21,
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
    parameter int          NUM_DIGITS      = 8
) (
    input  logic                      clk,
    input  logic                      nrst,
    input  logic [NUM_PB-1:0]         pb_raw,
    output logic [NUM_PB-1:0]         pb_level,
    output logic [NUM_PB-1:0]         pb_rise,
    input  logic [4*NUM_DIGITS-1:0]   disp_value,
    input  logic [NUM_DIGITS-1:0]     disp_dp,
    input  logic [NUM_DIGITS-1:0]     disp_blank,
    input  logic                      disp_load,
    output logic [8*NUM_DIGITS-1:0]   ss
);

    localparam int             CW      = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES - 16'd1);

    logic [NUM_PB-1:0] s1;
    logic [NUM_PB-1:0] s2;
    logic [NUM_PB-1:0] stable;
    logic [NUM_PB-1:0] accept;
    logic [NUM_PB-1:0] rise_next;
    logic [NUM_PB-1:0] rise_q;
    logic [CW-1:0]     cnt [NUM_PB];
    logic [8*NUM_DIGITS-1:0] ss_q;

    function automatic logic [6:0] hex7(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            default: seg = 7'h71;
        endcase
        return seg;
    endfunction

    always_ff @(posedge clk) begin
        if (!nrst) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= pb_raw;
            s2 <= s1;
        end
    end

    // A change is accepted on the edge where its hold count has reached DEBOUNCE_CYCLES-1.
    always_comb begin
        accept    = '0;
        rise_next = '0;
        for (int i = 0; i < NUM_PB; i++) begin
            accept[i]    = (s2[i] != stable[i]) && (cnt[i] == CNT_MAX);
            rise_next[i] = accept[i] & s2[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            stable <= '0;
            rise_q <= '0;
            for (int i = 0; i < NUM_PB; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            rise_q <= rise_next;
            for (int i = 0; i < NUM_PB; i++) begin
                if (s2[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (accept[i]) begin
                    stable[i] <= s2[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

`ifdef TEAM_09_PB_TOGGLE_EN
    logic [NUM_PB-1:0] tog;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            tog <= '0;
        end else begin
            tog <= tog ^ rise_next;
        end
    end

    assign pb_level = tog;
`else
    assign pb_level = stable;
`endif

    assign pb_rise = rise_q;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            ss_q <= '0;
        end else if (disp_load) begin
            for (int k = 0; k < NUM_DIGITS; k++) begin
                if (disp_blank[k]) begin
                    ss_q[8*k +: 8] <= 8'h00;
                end else begin
                    ss_q[8*k +: 8] <= {disp_dp[k], hex7(disp_value[4*k +: 4])};
                end
            end
        end
    end

    assign ss = ss_q;

endmodule

// File: tb/tb_team_09_fpga_io.sv
// tb/tb_team_09_fpga_io.sv - directed self-checking bench for team_09_fpga_io
module tb_team_09_fpga_io;

    logic        clk;
    logic        nrst;
    logic [3:0]  pb_raw;
    logic [3:0]  pb_level;
    logic [3:0]  pb_rise;
    logic [7:0]  disp_value;
    logic [1:0]  disp_dp;
    logic [1:0]  disp_blank;
    logic        disp_load;
    logic [15:0] ss;

    int total = 0;
    int bad   = 0;

    logic [3:0] exp_stab = 4'h0;
    logic [3:0] exp_tog  = 4'h0;

    team_09_fpga_io #(
        .NUM_PB          (4),
        .DEBOUNCE_CYCLES (16'd4),
        .NUM_DIGITS      (2)
    ) dut (
        .clk        (clk),
        .nrst       (nrst),
        .pb_raw     (pb_raw),
        .pb_level   (pb_level),
        .pb_rise    (pb_rise),
        .disp_value (disp_value),
        .disp_dp    (disp_dp),
        .disp_blank (disp_blank),
        .disp_load  (disp_load),
        .ss         (ss)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic [3:0] lvl();
`ifdef TEAM_09_PB_TOGGLE_EN
        return exp_tog;
`else
        return exp_stab;
`endif
    endfunction

    // Drive pb_raw and walk the 6-edge acceptance window, checking every cycle.
    task automatic settle(input logic [3:0] raw, input logic [3:0] new_stab, input logic [3:0] rise_m);
        pb_raw = raw;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("pre_rise", {12'h0, pb_rise}, 16'h0);
            chk("pre_lvl", {12'h0, pb_level}, {12'h0, lvl()});
        end
        tick();
        exp_stab = new_stab;
        exp_tog  = exp_tog ^ rise_m;
        chk("acc_rise", {12'h0, pb_rise}, {12'h0, rise_m});
        chk("acc_lvl", {12'h0, pb_level}, {12'h0, lvl()});
        tick();
        chk("post_rise", {12'h0, pb_rise}, 16'h0);
        chk("post_lvl", {12'h0, pb_level}, {12'h0, lvl()});
    endtask

    initial begin
        nrst       = 1'b0;
        pb_raw     = 4'hF;
        disp_value = 8'h12;
        disp_dp    = 2'b11;
        disp_blank = 2'b00;
        disp_load  = 1'b1;
        repeat (3) tick();
        chk("rst_lvl", {12'h0, pb_level}, 16'h0);
        chk("rst_rise", {12'h0, pb_rise}, 16'h0);
        chk("rst_ss", ss, 16'h0000);

        // Buttons held through reset are re-accepted 6 edges after release.
        nrst      = 1'b1;
        disp_load = 1'b0;
        settle(4'hF, 4'hF, 4'hF);
        chk("rst_ss_hold", ss, 16'h0000);

        settle(4'h0, 4'h0, 4'h0);

        // Clean press and release of pb0
        settle(4'h1, 4'h1, 4'h1);
        settle(4'h0, 4'h0, 4'h0);

        // Glitch of 3 cycles on pb1 never accepted
        pb_raw = 4'h2;
        repeat (3) tick();
        pb_raw = 4'h0;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("glitch_rise", {12'h0, pb_rise}, 16'h0);
            chk("glitch_lvl", {12'h0, pb_level}, {12'h0, lvl()});
        end
        settle(4'h2, 4'h2, 4'h2);
        settle(4'h0, 4'h0, 4'h0);

        // Simultaneous buttons
        settle(4'hA, 4'hA, 4'hA);
        settle(4'h0, 4'h0, 4'h0);

        // Two presses of pb2 (toggle behaviour in toggle build)
        settle(4'h4, 4'h4, 4'h4);
        settle(4'h0, 4'h0, 4'h0);
        settle(4'h4, 4'h4, 4'h4);
        settle(4'h0, 4'h0, 4'h0);

        // Display register
        disp_value = 8'hA3;
        disp_dp    = 2'b10;
        disp_blank = 2'b00;
        disp_load  = 1'b1;
        tick();
        chk("ss_a3", ss, 16'hF74F);
        disp_load  = 1'b0;
        disp_value = 8'h00;
        tick();
        chk("ss_hold", ss, 16'hF74F);
        tick();
        chk("ss_hold2", ss, 16'hF74F);
        disp_value = 8'hA3;
        disp_blank = 2'b01;
        disp_load  = 1'b1;
        tick();
        chk("ss_blank0", ss, 16'hF700);
        disp_value = 8'h5E;
        disp_dp    = 2'b01;
        disp_blank = 2'b00;
        tick();
        chk("ss_5e", ss, 16'h6DF9);
        disp_value = 8'hBD;
        disp_dp    = 2'b00;
        tick();
        chk("ss_bd", ss, 16'h7C5E);
        disp_blank = 2'b11;
        tick();
        chk("ss_blank_all", ss, 16'h0000);
        disp_load = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/team_09_fpga_io.md
# team_09_fpga_io

FPGA-side I/O conditioning stage for the Team 09 board build. It sits between the raw board pins (pushbuttons, seven-segment digits) and the team design core. Pushbuttons are synchronised and debounced, with per-button rising-edge pulses. A loadable display register drives hex-decoded seven-segment outputs. Button count, debounce window and digit count are parameters, so later boards reuse the block unchanged.

## Interface
- NUM_PB, default 21: number of pushbutton channels, range 1..32.
- DEBOUNCE_CYCLES, default 16'd50000: number of consecutive cycles a changed input must hold before it is accepted; must be ≥2.
- NUM_DIGITS, default 8: number of seven-segment digits, range 1..8.
- clk  input  1  system clock; all logic on the rising edge.
- nrst  input  1  synchronous, active-low reset.
- pb_raw  input  NUM_PB  asynchronous raw button levels, active high.
- pb_level  output  NUM_PB  debounced level per button (toggle state when configured, see Configuration).
- pb_rise  output  NUM_PB  one-cycle pulse on each accepted 0→1 transition.
- disp_value  input  4*NUM_DIGITS  hex nibble per digit; digit k is bits [4k+3:4k].
- disp_dp  input  NUM_DIGITS  decimal-point request per digit.
- disp_blank  input  NUM_DIGITS  1 = digit k dark.
- disp_load  input  1  capture disp_value, disp_dp and disp_blank into the display register.
- ss  output  8*NUM_DIGITS  segment outputs; digit k is bits [8k+7:8k], with bit0=a … bit6=g and bit7=dp, active high.

## Operation
- **Synchroniser.** Two flops per button, s1 <= pb_raw and s2 <= s1.
- **Debounce, per button.**
  - Each button has a counter of width $clog2(DEBOUNCE_CYCLES) and a stable bit.
  - If s2 == stable: counter <= 0.
  - If s2 != stable and counter < DEBOUNCE_CYCLES-1: counter increments.
  - If s2 != stable and counter == DEBOUNCE_CYCLES-1: stable <= s2 and counter <= 0.
  - The counter never wraps.
  - A glitch shorter than DEBOUNCE_CYCLES sampled cycles clears the counter on return and is never accepted.
- **Edge pulse.**
  - pb_rise[i] is registered and is 1 only in the cycle right after the edge where stable[i] goes 0→1.
  - A 1→0 acceptance produces no pulse.
  - Buttons are fully independent, so simultaneous acceptances on several buttons pulse together.
- **Display register.**
  - On an edge with disp_load=1, each digit's register is loaded:
    - 8'h00 if disp_blank[k]=1;
    - otherwise {disp_dp[k], hex7(disp_value[4k+3:4k])}.
  - With disp_load=0 the register holds.
  - hex7 codes: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
- **Reset.** While nrst=0 at an edge:
  - s1, s2, stable, counters, toggle state, pb_rise, pb_level and ss all go to 0.
  - Reset in the middle of a debounce discards the partial count.
  - A button held through reset is re-accepted DEBOUNCE_CYCLES+2 cycles after reset is released, and produces a pb_rise pulse then.

## Timing
- pb_raw change to pb_level / pb_rise is DEBOUNCE_CYCLES+2 edges:
  - the change is captured into s1 at edge 1 and into s2 at edge 2;
  - stable flips at edge 2+DEBOUNCE_CYCLES;
  - pb_rise is high for exactly one cycle after that edge.
- disp_load to ss is 1 cycle: ss updates at the same edge that samples disp_load=1.
- All outputs come straight from flops; there are no combinational paths from inputs to outputs.

## Configuration
- TEAM_09_PB_TOGGLE_EN:
  - **Defined:** each button has a toggle flop that inverts on every pb_rise. pb_level carries the toggle state and updates in the same cycle pb_rise is high.
  - **Undefined:** pb_level == stable and no toggle flops are built.
  - pb_rise behaves identically in both builds.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, NUM_PB=4, NUM_DIGITS=2.
- **Reset.** Hold nrst=0 for 3 cycles with pb_raw=4'hF and disp_load=1 → pb_level=0, pb_rise=0, ss=16'h0000.
  - Release reset → pb_level=4'hF after 6 edges, plus one pb_rise=4'hF pulse.
- **Clean press.** pb_raw[0] 0→1 held → pb_level[0]=1 and pb_rise[0]=1 after edge 6. pb_rise[0] returns to 0 on the next cycle.
- **Glitch rejection.**
  - pb_raw[1] high for 3 cycles then low → pb_level[1] and pb_rise[1] stay 0.
  - Then high for 4+ cycles → accepted at edge 6 from the last rise.
- **Simultaneous buttons.**
  - pb_raw=4'b1010 at one edge → pb_rise=4'b1010 in a single cycle.
  - Release both → pb_level returns to 0 with no pulse.
- **Display.**
  - disp_value=8'hA3, disp_dp=2'b10, disp_blank=2'b00, disp_load=1 for one cycle → ss=16'hF74F next cycle, held after disp_load drops.
  - Then disp_blank=2'b01 with a load → ss=16'hF700.
- **Toggle build** (TEAM_09_PB_TOGGLE_EN defined).
  - Two clean presses of pb_raw[2] → pb_level[2] goes 0→1→0, each change coincident with a pb_rise[2] pulse.
  - Releases leave pb_level unchanged.
